// File: rtl/intctrl_pkg.sv
// Shared pi1 slave definitions: bus opcode encoding, interrupt controller FSM states
// and an index-width helper.
package intctrl_pkg;

  typedef enum logic [1:0] {
    PI1_NONE  = 2'd0,
    PI1_WRITE = 2'd1,
    PI1_READ  = 2'd2,
    PI1_RDWR  = 2'd3
  } pi1_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_REQ    = 2'd2,
    ST_WAIT   = 2'd3
  } intc_state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intctrl_rrsel.sv
// Round-robin picker: finds the first ready destination after the last-served one,
// wrapping from N-1 back to 0.
module intctrl_rrsel #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  rdy_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int c;
    c       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last_i) + k) % N;
      if (!found_o && rdy_i[c]) begin
        found_o = 1'b1;
        idx_o   = IW'(c);
      end
    end
  end

endmodule

// File: rtl/intctrl.sv
// Interrupt controller: latches level requests from device sources and dispatches them
// one at a time to ready processing units; software acknowledges through the pi1 port.
module intctrl
  import intctrl_pkg::*;
#(
  parameter int SRCCOUNT  = 2,
  parameter int DSTCOUNT  = 2,
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [SRCCOUNT-1:0]    src_i,
  output logic [SRCCOUNT-1:0]    src_ack_o,
  output logic [DSTCOUNT-1:0]    intrqst_o,
  input  logic [DSTCOUNT-1:0]    intrdy_i,
  input  logic [1:0]             pi1_op_i,
  input  logic [ADDRBITSZ-1:0]   pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0] pi1_sel_i,
  output logic                   pi1_rdy_o
);

  localparam int SIW = idx_w(SRCCOUNT);
  localparam int DIW = idx_w(DSTCOUNT);

  intc_state_t         state_q;
  logic [SRCCOUNT-1:0] pending_q, inservice_q, ack_q;
  logic [SRCCOUNT-1:0] pending_d, inservice_d;
  logic [SRCCOUNT-1:0] capture, dispatch_clr, wr_clr;
  logic [DSTCOUNT-1:0] rqst_q, dvld_q;
  logic [SIW-1:0]      did_q [DSTCOUNT];
  logic [DIW-1:0]      last_q, cur_q, pick;
  logic [SIW-1:0]      sel_src;
  logic                found, dispatch;
  logic                addr_hit, rd_en, wr_en;
  logic [DIW-1:0]      widx;
  pi1_op_t             op;
  logic                unused_sel;

  assign unused_sel = ^pi1_sel_i;

  assign op       = pi1_op_t'(pi1_op_i);
  assign addr_hit = pi1_addr_i < ADDRBITSZ'(DSTCOUNT);
  assign widx     = pi1_addr_i[DIW-1:0];
  assign rd_en    = addr_hit && (op == PI1_READ || op == PI1_RDWR);
  assign wr_en    = addr_hit && (op == PI1_WRITE || op == PI1_RDWR)
                    && (pi1_data_i < ARCHBITSZ'(SRCCOUNT));

  intctrl_rrsel #(.N(DSTCOUNT), .IW(DIW)) u_rrsel (
    .rdy_i  (intrdy_i),
    .last_i (last_q),
    .found_o(found),
    .idx_o  (pick)
  );

  // Lowest-index pending source wins.
  always_comb begin
    sel_src = '0;
    for (int i = SRCCOUNT - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_src = SIW'(i);
    end
  end

  always_comb begin
    wr_clr = '0;
    if (wr_en) wr_clr[pi1_data_i[SIW-1:0]] = 1'b1;
  end

  // Capture looks at registered inservice, so a same-cycle acknowledge re-arms a cycle later.
  assign capture      = src_i & ~pending_q & ~inservice_q;
  assign dispatch     = (state_q == ST_SELECT) && found;
  assign dispatch_clr = dispatch ? (SRCCOUNT'(1) << sel_src) : '0;
  assign pending_d    = (pending_q | capture) & ~dispatch_clr;
  assign inservice_d  = (inservice_q & ~wr_clr) | dispatch_clr;

  always_comb begin
    pi1_data_o = '1;
    if (addr_hit && dvld_q[widx]) pi1_data_o = ARCHBITSZ'(did_q[widx]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      inservice_q <= '0;
      ack_q       <= '0;
      rqst_q      <= '0;
      dvld_q      <= '0;
      last_q      <= DIW'(DSTCOUNT - 1);
      cur_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      inservice_q <= inservice_q == inservice_d ? inservice_q : inservice_d;
      ack_q       <= capture;
      // A dispatch into the slot being read keeps the new id.
      if (rd_en) dvld_q[widx] <= 1'b0;
      if (dispatch) begin
        dvld_q[pick] <= 1'b1;
        did_q[pick]  <= sel_src;
      end
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) state_q <= ST_SELECT;
        end
        ST_SELECT: begin
          if (found) begin
            rqst_q  <= DSTCOUNT'(1) << pick;
            last_q  <= pick;
            cur_q   <= pick;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!intrdy_i[cur_q]) begin
            rqst_q  <= '0;
            state_q <= ST_WAIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src_ack_o = ack_q;
  assign intrqst_o = rqst_q;
  assign pi1_rdy_o = 1'b1;

endmodule

// File: tb/tb_intctrl.sv
// Self-checking bench for intctrl: directed scenarios plus randomized traffic compared
// cycle by cycle against a behavioural model of the controller.
module tb_intctrl;

  localparam int S   = 2;
  localparam int D   = 2;
  localparam int AW  = 32;
  localparam int ABW = AW - $clog2(AW/8);

  logic           clk = 1'b0;
  logic           rst;
  logic [S-1:0]   src, ack;
  logic [D-1:0]   rqst, rdy;
  logic [1:0]     op;
  logic [ABW-1:0] addr;
  logic [AW-1:0]  wdata, rdata;
  logic [AW/8-1:0] sel;
  logic           prdy;
  logic [AW-1:0]  rd_seen;

  always #5 clk = ~clk;

  intctrl #(.SRCCOUNT(S), .DSTCOUNT(D), .ARCHBITSZ(AW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .src_i     (src),
    .src_ack_o (ack),
    .intrqst_o (rqst),
    .intrdy_i  (rdy),
    .pi1_op_i  (op),
    .pi1_addr_i(addr),
    .pi1_data_i(wdata),
    .pi1_data_o(rdata),
    .pi1_sel_i (sel),
    .pi1_rdy_o (prdy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: sets of pending / in-service sources, per-PU id slots (-1 = empty),
  // and the dispatcher phase (0 idle, 1 looking for a PU, 2 requesting, 3 cooling off).
  bit [S-1:0] m_pend, m_insv, m_ack;
  int         m_slot [D];
  int         m_last, m_srv, m_phase;

  function automatic logic [31:0] m_read(input int a);
    if (a < D && m_slot[a] >= 0) return 32'(m_slot[a]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [D-1:0] m_rqst();
    if (m_srv < 0) return '0;
    return D'(1) << m_srv;
  endfunction

  task automatic m_step(input logic r, input logic [S-1:0] s, input logic [D-1:0] y,
                        input logic [1:0] o, input int a, input logic [31:0] w);
    int d, sv;
    if (r) begin
      m_pend = '0; m_insv = '0; m_ack = '0;
      for (int i = 0; i < D; i++) m_slot[i] = -1;
      m_last = D - 1; m_srv = -1; m_phase = 0;
      return;
    end
    m_ack = '0;
    for (int n = 0; n < S; n++)
      if (s[n] && !m_pend[n] && !m_insv[n]) m_ack[n] = 1'b1;
    if (o[1] && a < D) m_slot[a] = -1;
    if (o[0] && a < D && w < S) m_insv[int'(w)] = 1'b0;
    case (m_phase)
      0: if (m_pend != 0) m_phase = 1;
      1: begin
        d = -1;
        for (int k = 1; k <= D; k++)
          if (d < 0 && y[(m_last + k) % D]) d = (m_last + k) % D;
        if (d >= 0) begin
          sv = 0;
          for (int n = S - 1; n >= 0; n--) if (m_pend[n]) sv = n;
          m_pend[sv] = 1'b0; m_insv[sv] = 1'b1;
          m_slot[d] = sv; m_srv = d; m_last = d; m_phase = 2;
        end
      end
      2: if (!y[m_srv]) begin m_srv = -1; m_phase = 3; end
      default: m_phase = 0;
    endcase
    m_pend |= m_ack;
  endtask

  task automatic tick(input logic r, input logic [S-1:0] s, input logic [D-1:0] y,
                      input logic [1:0] o, input int a, input logic [31:0] w);
    rst = r; src = s; rdy = y; op = o; addr = ABW'(a); wdata = w; sel = (AW/8)'($urandom);
    #1;
    rd_seen = rdata;
    check_eq("rdata", rdata, m_read(a));
    check_eq("pi1_rdy", {31'd0, prdy}, 32'd1);
    @(posedge clk);
    m_step(r, s, y, o, a, w);
    @(negedge clk);
    check_eq("intrqst", 32'(rqst), 32'(m_rqst()));
    check_eq("src_ack", 32'(ack), 32'(m_ack));
    check_eq("onehot", 32'($countones(rqst) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; src = '0; rdy = '0; op = '0; addr = '0; wdata = '0; sel = '0;
    repeat (2) @(posedge clk);
    m_step(1'b1, '0, '0, 2'd0, 0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_rqst", 32'(rqst), 32'd0);
    check_eq("rst_ack", 32'(ack), 32'd0);
    check_eq("rst_rd0", rdata, 32'hFFFF_FFFF);
  endtask

  initial begin
    int a;
    logic [1:0] o;
    logic [31:0] w;

    // Single source to PU0, release, then destructive read of the id slot.
    do_reset();
    tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    check_eq("s24_ack", 32'(ack), 32'h1);
    check_eq("s24_rq_early", 32'(rqst), 32'h0);
    tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    check_eq("s24_rq", 32'(rqst), 32'h1);
    tick(0, 2'b01, 2'b10, 2'd0, 0, 0);
    check_eq("s24_rq_drop", 32'(rqst), 32'h0);
    tick(0, 2'b01, 2'b10, 2'd2, 0, 0);
    check_eq("s24_rd_first", rd_seen, 32'h0);
    tick(0, 2'b01, 2'b10, 2'd2, 0, 0);
    check_eq("s24_rd_again", rd_seen, 32'hFFFF_FFFF);

    // Two simultaneous sources fan out round-robin.
    do_reset();
    tick(0, 2'b11, 2'b11, 2'd0, 0, 0);
    check_eq("s25_ack", 32'(ack), 32'h3);
    tick(0, 2'b11, 2'b11, 2'd0, 0, 0);
    tick(0, 2'b11, 2'b11, 2'd0, 0, 0);
    check_eq("s25_rq0", 32'(rqst), 32'h1);
    repeat (3) tick(0, 2'b11, 2'b10, 2'd0, 0, 0);
    tick(0, 2'b11, 2'b10, 2'd0, 0, 0);
    check_eq("s25_rq1", 32'(rqst), 32'h2);
    tick(0, 2'b11, 2'b10, 2'd2, 0, 0);
    check_eq("s25_id0", rd_seen, 32'h0);
    tick(0, 2'b11, 2'b10, 2'd2, 1, 0);
    check_eq("s25_id1", rd_seen, 32'h1);

    // No ready PU: request withheld until PU1 becomes ready.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(0, 2'b01, 2'b00, 2'd0, 0, 0);
      check_eq("s26_hold", 32'(rqst), 32'h0);
    end
    tick(0, 2'b01, 2'b10, 2'd0, 0, 0);
    check_eq("s26_rq", 32'(rqst), 32'h2);

    // Acknowledge while the source is still asserted re-arms one cycle later.
    do_reset();
    repeat (3) tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    tick(0, 2'b01, 2'b00, 2'd0, 0, 0);
    tick(0, 2'b01, 2'b00, 2'd0, 0, 0);
    tick(0, 2'b01, 2'b00, 2'd1, 0, 0);
    check_eq("s27_no_same", 32'(ack), 32'h0);
    tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    check_eq("s27_rearm", 32'(ack), 32'h1);
    tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    tick(0, 2'b01, 2'b11, 2'd0, 0, 0);
    check_eq("s27_redeliver", 32'(rqst), 32'h2);

    // Reset in the middle of a request.
    tick(1, 2'b00, 2'b11, 2'd0, 0, 0);
    check_eq("s28_rq", 32'(rqst), 32'h0);
    tick(0, 2'b00, 2'b11, 2'd2, 0, 0);
    check_eq("s28_rd0", rd_seen, 32'hFFFF_FFFF);
    tick(0, 2'b00, 2'b11, 2'd2, 1, 0);
    check_eq("s28_rd1", rd_seen, 32'hFFFF_FFFF);

    // Out-of-range acknowledge data and out-of-range read address.
    do_reset();
    repeat (3) tick(0, 2'b10, 2'b11, 2'd0, 0, 0);
    check_eq("s29_rq", 32'(rqst), 32'h1);
    tick(0, 2'b10, 2'b00, 2'd0, 0, 0);
    tick(0, 2'b10, 2'b00, 2'd0, 0, 0);
    tick(0, 2'b10, 2'b00, 2'd1, 0, 7);
    for (int i = 0; i < 3; i++) begin
      tick(0, 2'b10, 2'b00, 2'd0, 0, 0);
      check_eq("s29_no_ack", 32'(ack), 32'h0);
    end
    tick(0, 2'b10, 2'b00, 2'd2, 5, 0);
    check_eq("s29_rd5", rd_seen, 32'hFFFF_FFFF);
    tick(0, 2'b10, 2'b00, 2'd3, 0, 0);
    check_eq("s29_rd0", rd_seen, 32'h1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1));
      o = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      w = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2));
      tick(($urandom_range(0, 99) == 0), S'($urandom), D'($urandom), o, a, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
